// File: rtl/fifo128_rd_stream.sv
// Drains a non-FWFT 128-bit sync FIFO into a ready/valid stream with burst framing.
// A 2-entry skid buffer plus one in-flight credit keeps one word per clock.
module fifo128_rd_stream #(
  parameter int unsigned BURST_WORDS = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               en,
  output logic               fifo_rd_en,
  input  logic [127:0]       fifo_dout,
  input  logic               fifo_empty,
  input  logic               fifo_valid,
  output logic [127:0]       m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [15:0] LAST_BEAT = 16'(BURST_WORDS - 1);

  state_t       state, state_next;
  logic [127:0] data0, data1;
  logic         last0, last1;
  logic [1:0]   occ;
  logic         inflight;
  logic [15:0]  beat;
  logic         armed;

  logic         fire, full, push, drop, push_last, credit_ok, issue_ok;
  logic [2:0]   pending;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = data0;
  assign m_last    = m_valid & last0;
  assign fire      = m_valid & m_ready;
  assign full      = (occ == 2'd2);
  assign push      = fifo_valid & armed & ~(full & ~fire);
  assign drop      = fifo_valid & armed & full & ~fire;
  assign push_last = (beat == LAST_BEAT);

  assign pending   = {1'b0, occ} + {2'b0, inflight};
  assign credit_ok = pending < (3'd2 + {2'b0, fire});

  // Once en is low, issue only until the word that closes the current burst is
  // in flight, so the drain never reads into the next burst.
  assign issue_ok   = (state != IDLE) &
                      (en | ((beat != '0) & ~(inflight & push_last)));
  assign fifo_rd_en = issue_ok & ~fifo_empty & credit_ok;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (en) state_next = RUN;
      RUN:      if (!en) state_next = (beat != '0) ? STOPPING : IDLE;
      STOPPING: begin
        if (en)                    state_next = RUN;
        else if (push & push_last) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state    <= IDLE;
      data0    <= '0;
      data1    <= '0;
      last0    <= 1'b0;
      last1    <= 1'b0;
      occ      <= '0;
      inflight <= 1'b0;
      beat     <= '0;
      armed    <= 1'b0;
      word_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;
      armed    <= 1'b1;
      if (fire) word_cnt <= word_cnt + 1'b1;
      if (drop) overrun <= 1'b1;
      if (push) beat <= push_last ? '0 : beat + 16'd1;

      case ({push, fire})
        2'b10: begin
          if (occ == 2'd0) begin
            data0 <= fifo_dout;
            last0 <= push_last;
          end else begin
            data1 <= fifo_dout;
            last1 <= push_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            data0 <= fifo_dout;
            last0 <= push_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= fifo_dout;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
